varshift_gearbox: RTL and testbench
===================================

# varshift_gearbox

Parametrised variable-amount shift-in gearbox, successor to the fixed 8-bit, 3-bit-input variable shift register. Each input beat shifts 0..K serial bits into an accumulator, and every completed N-bit word is presented on a valid/ready output. Partial words can be flushed out, and shift direction (MSB-first or LSB-first) is a parameter. It sits between bit-serial/variable-length sources (line decoders, bit unpackers) and word-wide datapaths.

## Interface
- N, 8, output word width (≥2)
- K, 3, maximum bits per input beat (1..N)
- MSB_FIRST, 1, 1: first-received bit lands in out_data[N-1]; 0: first-received bit lands in out_data[0]
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_len  input  $clog2(K+1)  valid bits in beat (0..K); values >K treated as K
- in_data  input  K  MSB_FIRST=1: valid bits in_data[K-1 -: in_len], in_data[K-1] oldest; MSB_FIRST=0: in_data[in_len-1:0], in_data[0] oldest
- flush  input  1  single-cycle request to emit the residual partial word
- out_valid  output  1  word available
- out_ready  input  1  word consumed when out_valid && out_ready
- out_data  output  N  output word
- out_len  output  $clog2(N+1)  valid bits in out_data: N for full words, 1..N-1 for a flushed word
- level  output  $clog2(N+K)  bits currently held (0..N+K-1)

## Operation
- The accumulator holds up to N+K-1 bits in arrival order, and `level` counts them.
- **Push.** An accepted beat appends in_len bits after all held bits. in_len=0 is accepted with no change.
- **Pop.** When level ≥ N, out_valid=1 and out_data holds the oldest N bits:
  - MSB_FIRST=1: oldest bit at N-1.
  - MSB_FIRST=0: oldest bit at 0.
- A pop removes those N bits, and the remaining bits keep their order.
- **Ready rule.** in_ready = rst && state==FILL && (level < N || (out_valid && out_ready)).
- **Simultaneous push and pop** in the same cycle is legal: new level = level − N + in_len.
- **Level bound.** level never exceeds N+K-1; any accepted push that would exceed it is a design error (assertion).
- **State machine:**
  - FILL: normal operation. On flush, go to FLUSH. A beat accepted in the same cycle as flush is included in the flush.
  - FLUSH: in_ready=0. Full words keep draining normally.
    - When 0 < level < N: out_valid=1, out_len=level, valid bits in oldest-first position, unused bits zero (MSB_FIRST=1: low bits zero; MSB_FIRST=0: high bits zero).
    - On the handshake: level=0, return to FILL.
    - If level reaches 0 with no partial word pending, return to FILL the next cycle with no output.
  - flush while already in FLUSH is ignored.
- **Output stability.** While out_valid && !out_ready, out_data and out_len are held stable.

## Timing
- **Reset (rst low, asynchronous):**
  - level=0, accumulator=0, state=FILL.
  - out_valid=0, out_data=0, out_len=0, in_ready=0.
  - First beat is accepted on the first rising edge after release with in_valid=1.
- **Reset mid-operation** discards all held bits, including a pending flush.
- out_valid/out_data are registered: the word completed by the beat accepted at edge t is valid after edge t (visible in cycle t+1).
- Throughput: one input beat per cycle sustained while out_ready=1; one output word per cycle at most.
- After the last partial-word handshake, FLUSH→FILL takes effect at that edge, and in_ready may be 1 in the next cycle.

## Test plan
All scenarios use N=8, K=3, MSB_FIRST=1 unless noted.
- **Assembly:** beats (3,3'b101),(3,3'b110),(2,3'b11x) → one cycle after third beat: out_valid=1, out_data=8'b10111011, out_len=8, level=8; after pop level=0.
- **Residual carry:** beats 101,010,111 (len 3 each) with out_ready=1 → out_data=8'b10101011, then level=1; next beats (3,3'b000),(3,3'b111),(1,3'b1xx) → out_data=8'b10001111.
- **Backpressure:** level=10, out_ready=0 for 5 cycles → in_ready=0, out_data unchanged all 5 cycles; out_ready=1 with same-cycle beat len 3 → level 10−8+3=5.
- **Flush:** hold 5 bits 10110, pulse flush → in_ready=0, out_data=8'b10110000, out_len=5; after handshake level=0, in_ready=1. Flush with level=0 → no out_valid, back to FILL in 1 cycle.
- **Reset mid-stream:** level=6 in FLUSH, drop rst asynchronously between edges → out_valid=0, in_ready=0, level=0 immediately; after release, normal assembly resumes.
- **LSB-first and zero-length beats (MSB_FIRST=0):**
  - Beats (3,3'b101),(0,x),(3,3'b011),(2,3'bx10) → out_data=8'b10011101.
  - The 0-length beat is accepted with level unchanged.

Source files
------------

// File: rtl/varshift_gearbox.sv
// Variable-amount shift-in gearbox: beats of 0..K bits accumulate in arrival order and
// leave as N-bit words on a valid/ready port, with an optional flush of the residual bits.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FILL  | accepting beats, emitting full words as they complete
// S_FLUSH | input closed; drain full words, then the partial word, then FILL
module varshift_gearbox #(
   parameter int N         = 8,
   parameter int K         = 3,
   parameter int MSB_FIRST = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [$clog2(K+1)-1:0]    in_len,
   input  logic [K-1:0]              in_data,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N-1:0]              out_data,
   output logic [$clog2(N+1)-1:0]    out_len,
   output logic [$clog2(N+K)-1:0]    level
);

   localparam int LEN_W  = $clog2(K+1);
   localparam int OLEN_W = $clog2(N+1);
   localparam int LVL_W  = $clog2(N+K);
   localparam int ACC_W  = N + K - 1;

   typedef enum logic {S_FILL, S_FLUSH} state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                out_valid_q, out_valid_d;
   logic [N-1:0]        out_data_q, out_data_d;
   logic [OLEN_W-1:0]   out_len_q, out_len_d;

   logic                push, pop;
   logic [LEN_W-1:0]    len_eff;
   logic [K-1:0]        beat_bits;
   logic [ACC_W-1:0]    beat_ext, acc_pop;
   logic [LVL_W-1:0]    level_pop;
   logic [N-1:0]        word;

   assign in_ready = rst && (state_q == S_FILL) &&
                     ((level_q < LVL_W'(N)) || (out_valid_q && out_ready));
   assign push     = in_valid && in_ready;
   assign pop      = out_valid_q && out_ready;

   // Internally bit 0 of the accumulator is always the oldest bit, whatever the direction.
   always_comb begin
      len_eff   = (in_len > LEN_W'(K)) ? LEN_W'(K) : in_len;
      beat_bits = '0;
      for (int j = 0; j < K; j++) begin
         if (j < int'(len_eff))
            beat_bits[j] = (MSB_FIRST != 0) ? in_data[K-1-j] : in_data[j];
      end
      beat_ext          = '0;
      beat_ext[K-1:0]   = beat_bits;

      // A pop always removes exactly out_len bits: N for full words, level for a partial.
      level_pop = pop ? (level_q - LVL_W'(out_len_q)) : level_q;
      acc_pop   = pop ? (acc_q >> out_len_q) : acc_q;

      acc_d   = acc_pop;
      level_d = level_pop;
      if (push) begin
         acc_d   = acc_pop | (beat_ext << level_pop);
         level_d = level_pop + LVL_W'(len_eff);
      end

      state_d = state_q;
      case (state_q)
         S_FILL:  if (flush) state_d = S_FLUSH;
         S_FLUSH: if ((level_q == '0) || (pop && (out_len_q != OLEN_W'(N))))
                     state_d = S_FILL;
         default: state_d = S_FILL;
      endcase

      // Bits above level are always zero, so a partial word comes out zero-padded.
      word        = acc_d[N-1:0];
      out_valid_d = 1'b0;
      out_len_d   = '0;
      out_data_d  = '0;
      if (level_d >= LVL_W'(N)) begin
         out_valid_d = 1'b1;
         out_len_d   = OLEN_W'(N);
      end else if ((state_d == S_FLUSH) && (level_d != '0)) begin
         out_valid_d = 1'b1;
         out_len_d   = OLEN_W'(level_d);
      end
      if (out_valid_d) begin
         for (int i = 0; i < N; i++)
            out_data_d[(MSB_FIRST != 0) ? (N-1-i) : i] = word[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FILL;
         acc_q       <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_len   = out_len_q;
   assign level     = level_q;

   level_bound_a: assert property (@(posedge clk) disable iff (!rst)
                                   level_d <= LVL_W'(ACC_W));

endmodule

// File: tb/tb_varshift_gearbox.sv
// Directed bench for varshift_gearbox: one MSB-first and one LSB-first instance (N=8, K=3)
// driven from per-cycle vector tables, plus a hand-written asynchronous reset sequence.
module tb_varshift_gearbox;

   logic       clk = 1'b0;
   logic       rst;

   logic       m_in_valid, m_in_ready, m_flush, m_out_valid, m_out_ready;
   logic [1:0] m_in_len;
   logic [2:0] m_in_data;
   logic [7:0] m_out_data;
   logic [3:0] m_out_len, m_level;

   logic       l_in_valid, l_in_ready, l_flush, l_out_valid, l_out_ready;
   logic [1:0] l_in_len;
   logic [2:0] l_in_data;
   logic [7:0] l_out_data;
   logic [3:0] l_out_len, l_level;

   always #5 clk = ~clk;

   varshift_gearbox #(.N(8), .K(3), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst(rst),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_len(m_in_len), .in_data(m_in_data),
      .flush(m_flush), .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out_data(m_out_data), .out_len(m_out_len), .level(m_level));

   varshift_gearbox #(.N(8), .K(3), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst(rst),
      .in_valid(l_in_valid), .in_ready(l_in_ready), .in_len(l_in_len), .in_data(l_in_data),
      .flush(l_flush), .out_valid(l_out_valid), .out_ready(l_out_ready),
      .out_data(l_out_data), .out_len(l_out_len), .level(l_level));

   typedef struct {
      bit       lsb;
      bit       v;
      bit [1:0] len;
      bit [2:0] d;
      bit       fl;
      bit       ordy;
      bit       e_rdy;
      bit       e_ov;
      bit [7:0] e_od;
      bit [3:0] e_ol;
      bit [3:0] e_lvl;
   } vec_t;

   vec_t tbl_m[$];
   vec_t tbl_l[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(bit lsb, bit v, int len, int d, bit fl, bit ordy,
                               bit rdy, bit ov, int od, int ol, int lvl);
      vec_t t;
      t.lsb = lsb;  t.v = v;  t.len = 2'(len);  t.d = 3'(d);  t.fl = fl;  t.ordy = ordy;
      t.e_rdy = rdy;  t.e_ov = ov;  t.e_od = 8'(od);  t.e_ol = 4'(ol);  t.e_lvl = 4'(lvl);
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m_in_valid = 0; m_in_len = 0; m_in_data = 0; m_flush = 0; m_out_ready = 0;
      l_in_valid = 0; l_in_len = 0; l_in_data = 0; l_flush = 0; l_out_ready = 0;
   endtask

   // Drive one cycle, check in_ready before the edge and registered outputs after it.
   task automatic apply(input vec_t t, input int idx);
      idle_inputs();
      if (t.lsb) begin
         l_in_valid = t.v; l_in_len = t.len; l_in_data = t.d; l_flush = t.fl; l_out_ready = t.ordy;
      end else begin
         m_in_valid = t.v; m_in_len = t.len; m_in_data = t.d; m_flush = t.fl; m_out_ready = t.ordy;
      end
      #1;
      chk("in_ready", idx, 32'(t.lsb ? l_in_ready : m_in_ready), 32'(t.e_rdy));
      @(posedge clk);
      #1;
      chk("out_valid", idx, 32'(t.lsb ? l_out_valid : m_out_valid), 32'(t.e_ov));
      chk("out_data",  idx, 32'(t.lsb ? l_out_data  : m_out_data),  32'(t.e_od));
      chk("out_len",   idx, 32'(t.lsb ? l_out_len   : m_out_len),   32'(t.e_ol));
      chk("level",     idx, 32'(t.lsb ? l_level     : m_level),     32'(t.e_lvl));
   endtask

   task automatic chk_reset_state(input int idx);
      chk("rst m_in_ready",  idx, 32'(m_in_ready),  0);
      chk("rst m_out_valid", idx, 32'(m_out_valid), 0);
      chk("rst m_out_data",  idx, 32'(m_out_data),  0);
      chk("rst m_out_len",   idx, 32'(m_out_len),   0);
      chk("rst m_level",     idx, 32'(m_level),     0);
      chk("rst l_in_ready",  idx, 32'(l_in_ready),  0);
      chk("rst l_out_valid", idx, 32'(l_out_valid), 0);
      chk("rst l_level",     idx, 32'(l_level),     0);
   endtask

   initial begin
      //              lsb v len d     fl ordy rdy ov od            ol lvl
      // assembly
      tbl_m.push_back(mk(0,1,3,3'b101,0,0, 1,0,0,           0,3));
      tbl_m.push_back(mk(0,1,3,3'b110,0,0, 1,0,0,           0,6));
      tbl_m.push_back(mk(0,1,2,3'b110,0,0, 1,1,8'b10111011, 8,8));
      tbl_m.push_back(mk(0,0,0,0,     0,1, 1,0,0,           0,0));
      // residual carry with out_ready high
      tbl_m.push_back(mk(0,1,3,3'b101,0,1, 1,0,0,           0,3));
      tbl_m.push_back(mk(0,1,3,3'b010,0,1, 1,0,0,           0,6));
      tbl_m.push_back(mk(0,1,3,3'b111,0,1, 1,1,8'b10101011, 8,9));
      tbl_m.push_back(mk(0,1,3,3'b000,0,1, 1,0,0,           0,4));
      tbl_m.push_back(mk(0,1,3,3'b111,0,1, 1,0,0,           0,7));
      tbl_m.push_back(mk(0,1,1,3'b100,0,1, 1,1,8'b10001111, 8,8));
      tbl_m.push_back(mk(0,0,0,0,     0,1, 1,0,0,           0,0));
      // backpressure at level 10, then simultaneous push and pop
      tbl_m.push_back(mk(0,1,3,3'b101,0,0, 1,0,0,           0,3));
      tbl_m.push_back(mk(0,1,3,3'b110,0,0, 1,0,0,           0,6));
      tbl_m.push_back(mk(0,1,1,3'b100,0,0, 1,0,0,           0,7));
      tbl_m.push_back(mk(0,1,3,3'b011,0,0, 1,1,8'b10111010, 8,10));
      for (int i = 0; i < 5; i++)
         tbl_m.push_back(mk(0,1,3,3'b111,0,0, 0,1,8'b10111010, 8,10));
      tbl_m.push_back(mk(0,1,3,3'b010,0,1, 1,0,0,           0,5));
      // flush of 5 held bits 11010, input blocked until the handshake
      tbl_m.push_back(mk(0,0,0,0,     1,0, 1,1,8'b11010000, 5,5));
      tbl_m.push_back(mk(0,1,3,3'b111,0,0, 0,1,8'b11010000, 5,5));
      tbl_m.push_back(mk(0,0,0,0,     0,1, 0,0,0,           0,0));
      tbl_m.push_back(mk(0,1,3,3'b101,0,0, 1,0,0,           0,3));
      // beat accepted in the flush cycle is part of the flushed word
      tbl_m.push_back(mk(0,1,2,3'b010,1,0, 1,1,8'b10101000, 5,5));
      tbl_m.push_back(mk(0,0,0,0,     0,1, 0,0,0,           0,0));
      // flush with nothing held: one cycle in FLUSH, no output
      tbl_m.push_back(mk(0,0,0,0,     1,1, 1,0,0,           0,0));
      tbl_m.push_back(mk(0,1,3,3'b111,0,1, 0,0,0,           0,0));
      tbl_m.push_back(mk(0,1,3,3'b111,0,1, 1,0,0,           0,3));
      // flush while a full word is out: full word drains, then 1-bit partial; re-flush ignored
      tbl_m.push_back(mk(0,1,3,3'b000,0,0, 1,0,0,           0,6));
      tbl_m.push_back(mk(0,1,3,3'b101,0,0, 1,1,8'b11100010, 8,9));
      tbl_m.push_back(mk(0,0,0,0,     1,1, 1,1,8'b10000000, 1,1));
      tbl_m.push_back(mk(0,1,3,3'b111,1,1, 0,0,0,           0,0));
      tbl_m.push_back(mk(0,1,3,3'b111,0,0, 1,0,0,           0,3));
      // set up level 6 in FLUSH for the reset test
      tbl_m.push_back(mk(0,1,3,3'b010,0,0, 1,0,0,           0,6));
      tbl_m.push_back(mk(0,0,0,0,     1,0, 1,1,8'b11101000, 6,6));

      // LSB-first with a zero-length beat, then an LSB-first flush
      tbl_l.push_back(mk(1,1,3,3'b101,0,0, 1,0,0,           0,3));
      tbl_l.push_back(mk(1,1,0,3'b111,0,0, 1,0,0,           0,3));
      tbl_l.push_back(mk(1,1,3,3'b011,0,0, 1,0,0,           0,6));
      tbl_l.push_back(mk(1,1,2,3'b110,0,0, 1,1,8'b10011101, 8,8));
      tbl_l.push_back(mk(1,0,0,0,     0,1, 1,0,0,           0,0));
      tbl_l.push_back(mk(1,1,3,3'b011,0,0, 1,0,0,           0,3));
      tbl_l.push_back(mk(1,0,0,0,     1,0, 1,1,8'b00000011, 3,3));
      tbl_l.push_back(mk(1,0,0,0,     0,1, 0,0,0,           0,0));

      // held in reset: offered beats must not load
      idle_inputs();
      rst = 1'b0;
      m_in_valid = 1; m_in_len = 3; m_in_data = 3'b111;
      l_in_valid = 1; l_in_len = 3; l_in_data = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state(0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl_m[i]) apply(tbl_m[i], i);

      // asynchronous reset between edges while a partial word is pending
      idle_inputs();
      #3;
      rst = 1'b0;
      #1;
      chk_reset_state(100);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) apply(tbl_m[i], 200 + i);

      foreach (tbl_l[i]) apply(tbl_l[i], 300 + i);

      idle_inputs();
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
